input_pipeline_ctrl: RTL and testbench
======================================

// Module: input_pipeline_ctrl
// PURPOSE
//  Sequencer for the 35-stage input_pipeline shift register.
//  - Converts a valid/ready sample stream into the pipeline's clk_ena/in_stream controls.
//  - Tracks fill level and presents a window-valid/ready handshake to the downstream tap consumer.
//  - Provides a zero-flush sequence, so the pipeline needs no synchronous clear.
// PARAMETERS
//  WIDTH  1   sample width; must match the pipeline WIDTH
//  DEPTH  35  number of pipeline stages; must be >= 2
//  CNT_W  6   counter width; $clog2(DEPTH+1) minimum
// PORTS
//  clk         in   1      clock
//  reset       in   1      reset: asynchronous, active-high
//  s_valid     in   1      upstream sample valid
//  s_data      in   WIDTH  upstream sample
//  s_ready     out  1      sample accepted when s_valid & s_ready
//  pipe_ena    out  1      drives the pipeline clk_ena
//  pipe_data   out  WIDTH  drives the pipeline in_stream
//  win_valid   out  1      all DEPTH taps hold a new, unconsumed window
//  win_ready   in   1      consumer takes the window
//  flush_req   in   1      single-cycle pulse; request a zero flush
//  flush_busy  out  1      flush in progress
//  fill_level  out  CNT_W  valid samples in the pipeline, 0..DEPTH
// BEHAVIOUR
//  Reset: state=FILL; win_valid=0, flush_busy=0, fill_level=0, flush counter=0.
//  Combinational outputs during reset: pipe_ena=0, s_ready=0.
//  States:
//   - FILL: fill_level < DEPTH.
//   - RUN: fill_level == DEPTH.
//   - FLUSH: shifting zeros.
//  s_ready (combinational):
//   - FILL/RUN: !flush_req & (!win_valid | win_ready).
//   - FLUSH: s_ready=0.
//  Shift:
//   - In FILL/RUN, shift = s_valid & s_ready.
//   - pipe_ena = shift; pipe_data = s_data.
//   - The pipeline registers load on the same edge, giving zero added latency.
//  fill_level:
//   - Increments on each shift.
//   - Saturates at DEPTH.
//   - FILL->RUN on the shift that makes fill_level == DEPTH.
//  win_valid (registered):
//   - Set on the edge of any shift whose post-shift fill_level == DEPTH.
//   - Cleared on win_valid & win_ready with no shift.
//   - Ready and shift in the same cycle: win_valid stays 1 (back-to-back windows, one per cycle).
//   - A window is never overwritten while pending unconsumed.
//  flush_req in FILL/RUN:
//   - Flush wins over a simultaneous s_valid; no sample is accepted that cycle.
//   - Next state FLUSH; win_valid cleared; flush counter loaded with DEPTH.
//  In FLUSH:
//   - pipe_ena=1, pipe_data=0, flush_busy=1.
//   - Counter decrements each cycle; exactly DEPTH zero shifts.
//   - After the last shift: fill_level=0, state FILL, flush_busy=0.
//  flush_req while in FLUSH is ignored; the flush is not restarted.
//  win_ready while win_valid=0 is ignored.
//  reset mid-flush or mid-fill: immediate return to reset values.
//   - Pipeline contents are reset by the same reset net.
// CONFIGURATION
//  STALL_CNT_EN defined:
//   - Adds output stall_count[15:0], reset 0.
//   - Increments every cycle with s_valid & !s_ready.
//   - Saturates at 16'hFFFF; cleared on flush entry.
//  STALL_CNT_EN undefined:
//   - No stall_count port and no counter logic.
//   - All other behaviour identical.
// STRUCTURE
//  Package input_pipeline_pkg:
//   - state enum {FILL, RUN, FLUSH}.
//   - DEPTH_DEF=35 and CNT_W_DEF=6 constants.
//  No sub-module. Fill and flush counters are inline; they are mutually exclusive and may share
//  one register.
//  The bench instantiates input_pipeline (WIDTH, DEPTH matched) downstream of this block.
// TESTING
//  - Reset release, s_valid=0 -> s_ready=1, pipe_ena=0, fill_level=0, win_valid=0.
//  - Fill with 35 samples 1,0,1,... s_valid held, win_ready=0 -> win_valid rises on the edge of
//    sample 35; fill_level=35; s_ready=0 after it.
//  - Streaming, win_ready=1, s_valid=1 for 20 cycles -> 20 shifts, win_valid stays 1, taps
//    match a reference delay line.
//  - Pending window, win_ready=0 for 5 cycles -> no pipe_ena, taps stable; win_ready=1 -> one
//    shift that cycle.
//  - flush_req with s_valid same cycle -> sample rejected; flush_busy=1 for exactly 35 cycles;
//    all taps 0; fill_level=0.
//  - reset pulse mid-flush (cycle 10) -> flush_busy=0, state FILL, fill_level=0 immediately.
//  - With STALL_CNT_EN defined, 7 blocked cycles -> stall_count=7.

Source files
------------

// File: rtl/input_pipeline_pkg.sv
// -----------------------------------------------------------------------------
// input_pipeline_pkg
//   Shared types and default sizes for the input_pipeline sequencer.
//   - state_e   : sequencer states (FILL, RUN, FLUSH)
//   - DEPTH_DEF : default number of pipeline stages
//   - CNT_W_DEF : default fill/flush counter width
// -----------------------------------------------------------------------------
package input_pipeline_pkg;

   typedef enum logic [1:0] {
      FILL  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } state_e;

   localparam int DEPTH_DEF = 35;
   localparam int CNT_W_DEF = 6;

endpackage : input_pipeline_pkg

// File: rtl/input_pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// input_pipeline_ctrl
//   Sequencer for the input_pipeline shift register. Turns a valid/ready
//   sample stream into the pipeline's clk_ena/in_stream controls, tracks how
//   many valid samples the pipeline holds, offers a window valid/ready
//   handshake to the tap consumer, and can flush the pipeline with zeros so
//   the pipeline itself needs no synchronous clear.
//
// Ports
//   clk         in   clock
//   reset       in   asynchronous, active-high reset
//   s_valid     in   upstream sample valid
//   s_data      in   upstream sample [WIDTH]
//   s_ready     out  sample accepted when s_valid & s_ready
//   pipe_ena    out  pipeline clk_ena
//   pipe_data   out  pipeline in_stream [WIDTH]
//   win_valid   out  all DEPTH taps hold a new, unconsumed window
//   win_ready   in   consumer takes the window
//   flush_req   in   single-cycle pulse requesting a zero flush
//   flush_busy  out  flush in progress
//   fill_level  out  valid samples in the pipeline, 0..DEPTH [CNT_W]
//   stall_count out  (STALL_CNT_EN only) cycles with s_valid & !s_ready [16]
//
// Configuration
//   STALL_CNT_EN : when defined, adds the saturating stall_count output.
// -----------------------------------------------------------------------------
module input_pipeline_ctrl
   import input_pipeline_pkg::*;
#(
   parameter int WIDTH = 1,
   parameter int DEPTH = DEPTH_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             s_valid,
   input  logic [WIDTH-1:0] s_data,
   output logic             s_ready,
   output logic             pipe_ena,
   output logic [WIDTH-1:0] pipe_data,
   output logic             win_valid,
   input  logic             win_ready,
   input  logic             flush_req,
   output logic             flush_busy,
   output logic [CNT_W-1:0] fill_level
`ifdef STALL_CNT_EN
   ,
   output logic [15:0]      stall_count
`endif
);

   localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] DEPTH_M1_C = CNT_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] ONE_C      = CNT_W'(1);

   state_e           state_q, state_d;
   // Fill level in FILL/RUN, remaining zero shifts in FLUSH.
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             win_valid_q, win_valid_d;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      win_valid_d = win_valid_q;
      s_ready     = 1'b0;
      pipe_ena    = 1'b0;
      pipe_data   = '0;

      case (state_q)
         FILL, RUN: begin
            // A window may only be replaced when it is absent or being taken
            // this very cycle, so a pending window is never overwritten.
            s_ready = !reset && !flush_req && (!win_valid_q || win_ready);
            if (flush_req) begin
               state_d     = FLUSH;
               cnt_d       = DEPTH_C;
               win_valid_d = 1'b0;
            end else begin
               if (win_valid_q && win_ready) begin
                  win_valid_d = 1'b0;
               end
               if (s_valid && s_ready) begin
                  pipe_ena  = 1'b1;
                  pipe_data = s_data;
                  // Shift that leaves the pipeline full: a fresh window
                  // appears on this edge (overrides the consume above).
                  if (cnt_q >= DEPTH_M1_C) begin
                     cnt_d       = DEPTH_C;
                     win_valid_d = 1'b1;
                     state_d     = RUN;
                  end else begin
                     cnt_d = cnt_q + ONE_C;
                  end
               end
            end
         end

         FLUSH: begin
            pipe_ena = !reset;
            if (cnt_q <= ONE_C) begin
               cnt_d   = '0;
               state_d = FILL;
            end else begin
               cnt_d = cnt_q - ONE_C;
            end
         end

         default: begin
            state_d     = FILL;
            cnt_d       = '0;
            win_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= FILL;
         cnt_q       <= '0;
         win_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         win_valid_q <= win_valid_d;
      end
   end

   assign win_valid  = win_valid_q;
   assign flush_busy = (state_q == FLUSH);
   // The shared counter holds the flush countdown while flushing; the
   // pipeline holds no valid window then, so report empty.
   assign fill_level = (state_q == FLUSH) ? '0 : cnt_q;

`ifdef STALL_CNT_EN
   logic [15:0] stall_q, stall_d;

   always_comb begin
      stall_d = stall_q;
      if ((state_q != FLUSH) && flush_req) begin
         stall_d = '0;
      end else if (s_valid && !s_ready && (stall_q != 16'hFFFF)) begin
         stall_d = stall_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_q <= '0;
      end else begin
         stall_q <= stall_d;
      end
   end

   assign stall_count = stall_q;
`endif

endmodule : input_pipeline_ctrl

// File: tb/tb_input_pipeline_ctrl.sv
module tb_input_pipeline_ctrl;

   localparam int WIDTH = 1;
   localparam int DEPTH = 35;
   localparam int CNT_W = 6;

   typedef logic [DEPTH*WIDTH-1:0] win_t;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             s_valid;
   logic [WIDTH-1:0] s_data;
   logic             s_ready;
   logic             pipe_ena;
   logic [WIDTH-1:0] pipe_data;
   logic             win_valid;
   logic             win_ready;
   logic             flush_req;
   logic             flush_busy;
   logic [CNT_W-1:0] fill_level;
`ifdef STALL_CNT_EN
   logic [15:0]      stall_count;
`endif

   int n_cmp = 0;
   int n_err = 0;
   int exp_fill = 0;

   always #5 clk = ~clk;

   input_pipeline_ctrl #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH),
      .CNT_W(CNT_W)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .s_valid    (s_valid),
      .s_data     (s_data),
      .s_ready    (s_ready),
      .pipe_ena   (pipe_ena),
      .pipe_data  (pipe_data),
      .win_valid  (win_valid),
      .win_ready  (win_ready),
      .flush_req  (flush_req),
      .flush_busy (flush_busy),
      .fill_level (fill_level)
`ifdef STALL_CNT_EN
      ,
      .stall_count(stall_count)
`endif
   );

   // Downstream input_pipeline: DEPTH-stage shift register, tap 0 newest.
   logic [WIDTH-1:0] taps [DEPTH];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) taps[i] <= '0;
      end else if (pipe_ena) begin
         taps[0] <= pipe_data;
         for (int i = 1; i < DEPTH; i++) taps[i] <= taps[i-1];
      end
   end

   // Reference delay line and window scoreboard.
   logic [WIDTH-1:0] hist [$];
   win_t             exp_q [$];

   function automatic win_t taps_vec();
      win_t v;
      for (int i = 0; i < DEPTH; i++) v[i*WIDTH +: WIDTH] = taps[i];
      return v;
   endfunction

   function automatic win_t hist_vec();
      win_t v;
      v = '0;
      for (int i = 0; i < DEPTH && i < hist.size(); i++)
         v[i*WIDTH +: WIDTH] = hist[hist.size()-1-i];
      return v;
   endfunction

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic accept(input logic [WIDTH-1:0] smp);
      hist.push_back(smp);
      if (hist.size() > DEPTH) void'(hist.pop_front());
      if (hist.size() == DEPTH) exp_q.push_back(hist_vec());
      if (exp_fill < DEPTH) exp_fill++;
   endtask

   task automatic consume_check();
      check("win_valid_at_take", 64'(win_valid), 64'(1));
      if (exp_q.size() == 0) check("window_sb_empty", 64'(1), 64'(0));
      else                   check("window", 64'(taps_vec()), 64'(exp_q.pop_front()));
   endtask

   // Fill n samples 1,0,1,... with no consumer; window appears on the edge
   // of the sample that makes the pipeline full.
   task automatic fill_n(input int n);
      win_ready = 1'b0;
      for (int k = 0; k < n; k++) begin
         s_valid = 1'b1;
         s_data  = (k % 2 == 0) ? '1 : '0;
         #1;
         check("fill_ena", 64'(pipe_ena), 64'(1));
         accept(s_data);
         tick();
         check("fill_lvl", 64'(fill_level), 64'(exp_fill));
         check("fill_winv", 64'(win_valid), 64'(exp_fill == DEPTH));
      end
      s_valid = 1'b0;
   endtask

   task automatic clear_model();
      hist.delete();
      exp_q.delete();
      exp_fill = 0;
   endtask

   initial begin
      int n;
      reset     = 1'b1;
      s_valid   = 1'b1;
      s_data    = '1;
      win_ready = 1'b0;
      flush_req = 1'b0;
      repeat (2) tick();
      check("rst_s_ready", 64'(s_ready), 64'(0));
      check("rst_pipe_ena", 64'(pipe_ena), 64'(0));

      // Reset release, idle input
      s_valid = 1'b0;
      reset   = 1'b0;
      #1;
      check("idle_s_ready", 64'(s_ready), 64'(1));
      check("idle_pipe_ena", 64'(pipe_ena), 64'(0));
      check("idle_fill", 64'(fill_level), 64'(0));
      check("idle_winv", 64'(win_valid), 64'(0));
      check("idle_busy", 64'(flush_busy), 64'(0));
      tick();

      // Initial fill, window pending
      fill_n(DEPTH);
      s_valid = 1'b1;
      #1;
      check("full_s_ready", 64'(s_ready), 64'(0));
      check("full_pipe_ena", 64'(pipe_ena), 64'(0));
      tick();

      // Streaming, one window per cycle
      for (int k = 0; k < 20; k++) begin
         s_valid   = 1'b1;
         win_ready = 1'b1;
         s_data    = WIDTH'($urandom_range(0, 1));
         #1;
         check("strm_s_ready", 64'(s_ready), 64'(1));
         check("strm_ena", 64'(pipe_ena), 64'(1));
         consume_check();
         accept(s_data);
         tick();
         check("strm_winv", 64'(win_valid), 64'(1));
      end
      check("ref_delay", 64'(taps_vec()), 64'(hist_vec()));

      // Pending window held for 5 cycles
      win_ready = 1'b0;
      s_valid   = 1'b1;
      s_data    = '1;
      for (int k = 0; k < 5; k++) begin
         #1;
         check("hold_ena", 64'(pipe_ena), 64'(0));
         tick();
         check("hold_taps", 64'(taps_vec()), 64'(exp_q[0]));
      end
      win_ready = 1'b1;
      #1;
      check("release_ena", 64'(pipe_ena), 64'(1));
      consume_check();
      accept(s_data);
      tick();
      check("release_winv", 64'(win_valid), 64'(1));

      // Consume without a new sample, then a stray win_ready
      s_valid = 1'b0;
      #1;
      check("take_ena", 64'(pipe_ena), 64'(0));
      consume_check();
      tick();
      check("take_winv", 64'(win_valid), 64'(0));
      tick();
      check("stray_winv", 64'(win_valid), 64'(0));
      check("stray_fill", 64'(fill_level), 64'(DEPTH));

      // Flush with a simultaneous sample
      win_ready = 1'b0;
      flush_req = 1'b1;
      s_valid   = 1'b1;
      s_data    = '1;
      #1;
      check("flreq_s_ready", 64'(s_ready), 64'(0));
      check("flreq_ena", 64'(pipe_ena), 64'(0));
      tick();
      n = 0;
      for (int c = 0; c < 100; c++) begin
         flush_req = (c == 5);
         #1;
         if (!flush_busy) break;
         n++;
         check("fl_ena", 64'(pipe_ena), 64'(1));
         check("fl_data", 64'(pipe_data), 64'(0));
         check("fl_s_ready", 64'(s_ready), 64'(0));
         tick();
      end
      flush_req = 1'b0;
      s_valid   = 1'b0;
      check("flush_len", 64'(n), 64'(DEPTH));
      check("post_fl_fill", 64'(fill_level), 64'(0));
      check("post_fl_winv", 64'(win_valid), 64'(0));
      check("post_fl_taps", 64'(taps_vec()), 64'(0));
      #1;
      check("post_fl_s_ready", 64'(s_ready), 64'(1));
      clear_model();
      tick();

      // Partial refill, then reset in the middle of a flush
      fill_n(12);
      check("refill_lvl", 64'(fill_level), 64'(12));
      flush_req = 1'b1;
      tick();
      flush_req = 1'b0;
      for (int c = 0; c < 10; c++) begin
         #1;
         check("mid_busy", 64'(flush_busy), 64'(1));
         tick();
      end
      reset = 1'b1;
      #1;
      check("rstfl_busy", 64'(flush_busy), 64'(0));
      check("rstfl_fill", 64'(fill_level), 64'(0));
      check("rstfl_ena", 64'(pipe_ena), 64'(0));
      check("rstfl_s_ready", 64'(s_ready), 64'(0));
      check("rstfl_taps", 64'(taps_vec()), 64'(0));
      tick();
      reset = 1'b0;
      clear_model();
      #1;
      check("rel_s_ready", 64'(s_ready), 64'(1));
      check("rel_busy", 64'(flush_busy), 64'(0));
      tick();

      // Full refill from FILL after reset, take the window
      fill_n(DEPTH);
      win_ready = 1'b1;
      #1;
      consume_check();
      tick();
      win_ready = 1'b0;
`ifdef STALL_CNT_EN
      check("stall_zero", 64'(stall_count), 64'(0));
`endif
      // One shift builds a new window, then 7 blocked cycles
      s_valid = 1'b1;
      s_data  = '0;
      #1;
      check("rewin_ena", 64'(pipe_ena), 64'(1));
      accept(s_data);
      tick();
      for (int k = 0; k < 7; k++) begin
         #1;
         check("blk_ena", 64'(pipe_ena), 64'(0));
         tick();
      end
      check("blk_taps", 64'(taps_vec()), 64'(exp_q[0]));
`ifdef STALL_CNT_EN
      check("stall_7", 64'(stall_count), 64'(7));
      s_valid   = 1'b0;
      flush_req = 1'b1;
      tick();
      flush_req = 1'b0;
      check("stall_clr", 64'(stall_count), 64'(0));
`endif
      s_valid = 1'b0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (time %0t)", $time);
      $fatal(1);
   end

endmodule : tb_input_pipeline_ctrl
